// File: rtl/code_seq_pkg.sv
// code_seq_pkg: shared mode constants and per-digit encoders for code_seq_gen.
//   MODE_*     : 3-bit code select values (5-7 behave as MODE_BIN)
//   gray_enc   : 4-bit binary -> reflected Gray
//   aiken_enc  : decimal digit -> Aiken (2421) code
//   xs3_enc    : decimal digit -> excess-3 (Stibitz) code
//   digit_enc  : decimal digit -> code digit for the selected decimal mode
package code_seq_pkg;

  localparam logic [2:0] MODE_BIN   = 3'd0;
  localparam logic [2:0] MODE_GRAY  = 3'd1;
  localparam logic [2:0] MODE_BCD   = 3'd2;
  localparam logic [2:0] MODE_AIKEN = 3'd3;
  localparam logic [2:0] MODE_XS3   = 3'd4;

  function automatic logic [3:0] gray_enc(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] aiken_enc(input logic [3:0] d);
    return (d < 4'd5) ? d : d + 4'd6;
  endfunction

  function automatic logic [3:0] xs3_enc(input logic [3:0] d);
    return d + 4'd3;
  endfunction

  function automatic logic [3:0] digit_enc(input logic [2:0] m, input logic [3:0] d);
    logic [3:0] r;
    case (m)
      MODE_AIKEN: r = aiken_enc(d);
      MODE_XS3:   r = xs3_enc(d);
      default:    r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/code_seq_gen_if.sv
// code_seq_gen_if: control/status bundle of code_seq_gen.
//   clr, en, wrap, mode (, dir) : sequencer controls (master drives)
//   code, last, wrapped         : sequencer outputs (slave drives)
// Optional macro CODE_SEQ_DOWN_EN adds the dir signal.
interface code_seq_gen_if #(
  parameter int unsigned NDIG = 1
);
  localparam int unsigned WIDTH = 4 * NDIG;

  logic             clr;
  logic             en;
  logic             wrap;
  logic [2:0]       mode;
`ifdef CODE_SEQ_DOWN_EN
  logic             dir;
`endif
  logic [WIDTH-1:0] code;
  logic             last;
  logic             wrapped;

`ifdef CODE_SEQ_DOWN_EN
  modport master (output clr, en, wrap, mode, dir, input code, last, wrapped);
  modport slave  (input clr, en, wrap, mode, dir, output code, last, wrapped);
`else
  modport master (output clr, en, wrap, mode, input code, last, wrapped);
  modport slave  (input clr, en, wrap, mode, output code, last, wrapped);
`endif

endinterface

// File: rtl/code_seq_decade.sv
// code_seq_decade: one 0..9 decade counter stage.
//   clk, reset, clr : clock, synchronous reset and restart (both clear q)
//   inc / carry_out : count up; carry_out = (q==9) & inc
//   dec / borrow_out: count down; borrow_out = (q==0) & dec (CODE_SEQ_DOWN_EN only)
//   q               : current digit
module code_seq_decade (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
`ifdef CODE_SEQ_DOWN_EN
  input  logic       dec,
  output logic       borrow_out,
`endif
  output logic [3:0] q,
  output logic       carry_out
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (inc) begin
      q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
    end
`ifdef CODE_SEQ_DOWN_EN
    else if (dec) begin
      q <= (q == 4'd0) ? 4'd9 : q - 4'd1;
    end
`endif
  end

  assign carry_out = inc && (q == 4'd9);
`ifdef CODE_SEQ_DOWN_EN
  assign borrow_out = dec && (q == 4'd0);
`endif

endmodule

// File: rtl/code_seq_gen.sv
// code_seq_gen: steps through binary / Gray / BCD / Aiken / excess-3 sequences
// over NDIG 4-bit digits, with enable, wrap-or-saturate and end flags.
//   clk, reset : clock, synchronous active-high reset
//   bus        : code_seq_gen_if.slave (clr, en, wrap, mode, [dir] in;
//                code, last, wrapped out)
// Optional macro CODE_SEQ_DOWN_EN: adds bus.dir, dir=1 counts down.
module code_seq_gen
  import code_seq_pkg::*;
#(
  parameter int unsigned NDIG      = 1,
  parameter logic [2:0]  INIT_MODE = MODE_BIN
) (
  input  logic          clk,
  input  logic          reset,
  code_seq_gen_if.slave bus
);

  localparam int unsigned WIDTH = 4 * NDIG;

  logic [2:0]       mode_q;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_nxt;
  logic [3:0]       dig_q [NDIG];
  logic [WIDTH-1:0] dec_code;
  logic [NDIG:0]    inc_chain;
  logic             wrapped_q;

  logic is_dec;
  logic dig_all9;
  logic at_last;
  logic adv;
  logic wrap_evt;
  logic down;
`ifdef CODE_SEQ_DOWN_EN
  logic [NDIG:0]    dec_chain;
  logic             dig_all0;
`endif

`ifdef CODE_SEQ_DOWN_EN
  assign down = bus.dir;
`else
  assign down = 1'b0;
`endif

  assign is_dec = (mode_q == MODE_BCD) || (mode_q == MODE_AIKEN) || (mode_q == MODE_XS3);

  always_comb begin
    dig_all9 = 1'b1;
`ifdef CODE_SEQ_DOWN_EN
    dig_all0 = 1'b1;
`endif
    for (int unsigned k = 0; k < NDIG; k++) begin
      if (dig_q[k] != 4'd9) dig_all9 = 1'b0;
`ifdef CODE_SEQ_DOWN_EN
      if (dig_q[k] != 4'd0) dig_all0 = 1'b0;
`endif
    end
  end

  // "last" is the end of the sequence in the current counting direction.
  always_comb begin
    at_last = is_dec ? dig_all9 : (&bin_q);
`ifdef CODE_SEQ_DOWN_EN
    if (down) at_last = is_dec ? dig_all0 : (bin_q == '0);
`endif
  end

  assign adv = bus.en && !(at_last && !bus.wrap);

  always_comb begin
    bin_nxt = bin_q + 1'b1;
`ifdef CODE_SEQ_DOWN_EN
    if (down) bin_nxt = bin_q - 1'b1;
`endif
  end

  // Only the counter belonging to the active mode moves; the other stays at 0.
  assign inc_chain[0] = adv && is_dec && !down;
`ifdef CODE_SEQ_DOWN_EN
  assign dec_chain[0] = adv && is_dec && down;
`endif

  for (genvar k = 0; k < NDIG; k++) begin : g_dig
    code_seq_decade u_decade (
      .clk        (clk),
      .reset      (reset),
      .clr        (bus.clr),
      .inc        (inc_chain[k]),
`ifdef CODE_SEQ_DOWN_EN
      .dec        (dec_chain[k]),
      .borrow_out (dec_chain[k+1]),
`endif
      .q          (dig_q[k]),
      .carry_out  (inc_chain[k+1])
    );
    assign dec_code[4*k +: 4] = digit_enc(mode_q, dig_q[k]);
  end

  // A carry/borrow out of the top digit is exactly a decimal wrap.
  always_comb begin
    if (is_dec) begin
      wrap_evt = inc_chain[NDIG];
`ifdef CODE_SEQ_DOWN_EN
      wrap_evt = inc_chain[NDIG] || dec_chain[NDIG];
`endif
    end else begin
      wrap_evt = adv && at_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= INIT_MODE;
      bin_q     <= '0;
      wrapped_q <= 1'b0;
    end else if (bus.clr) begin
      mode_q    <= bus.mode;
      bin_q     <= '0;
      wrapped_q <= 1'b0;
    end else begin
      if (adv && !is_dec) bin_q <= bin_nxt;
      wrapped_q <= wrap_evt;
    end
  end

  always_comb begin
    case (mode_q)
      MODE_GRAY:                     bus.code = bin_q ^ (bin_q >> 1);
      MODE_BCD, MODE_AIKEN, MODE_XS3: bus.code = dec_code;
      default:                       bus.code = bin_q;
    endcase
  end

  assign bus.last    = at_last;
  assign bus.wrapped = wrapped_q;

endmodule

// File: tb/tb_code_seq_gen.sv
// tb_code_seq_gen: drives one NDIG=1 (INIT_MODE=BIN) and one NDIG=2
// (INIT_MODE=BCD) code_seq_gen with identical stimulus and compares both to a
// sequence-index reference model. Honours CODE_SEQ_DOWN_EN when defined.
module tb_code_seq_gen;
  import code_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       clr;
  logic       en;
  logic       wrap;
  logic [2:0] mode;
  logic       dir;

  code_seq_gen_if #(.NDIG(1)) b1 ();
  code_seq_gen_if #(.NDIG(2)) b2 ();

  assign b1.clr  = clr;
  assign b1.en   = en;
  assign b1.wrap = wrap;
  assign b1.mode = mode;
  assign b2.clr  = clr;
  assign b2.en   = en;
  assign b2.wrap = wrap;
  assign b2.mode = mode;
`ifdef CODE_SEQ_DOWN_EN
  assign b1.dir  = dir;
  assign b2.dir  = dir;
`endif

  code_seq_gen #(.NDIG(1), .INIT_MODE(MODE_BIN)) u1 (.clk(clk), .reset(reset), .bus(b1));
  code_seq_gen #(.NDIG(2), .INIT_MODE(MODE_BCD)) u2 (.clk(clk), .reset(reset), .bus(b2));

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Reference model: position in the sequence, latched mode, pending pulse.
  int unsigned m_idx  [2];
  logic [2:0]  m_mode [2];
  logic        m_wr   [2];

  function automatic bit is_decimal(input logic [2:0] m);
    return (m == MODE_BCD) || (m == MODE_AIKEN) || (m == MODE_XS3);
  endfunction

  function automatic int unsigned seq_len(input int unsigned nd, input logic [2:0] m);
    if (is_decimal(m)) return (nd == 1) ? 10 : 100;
    return 1 << (4 * nd);
  endfunction

  function automatic bit cur_down();
`ifdef CODE_SEQ_DOWN_EN
    return dir;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] exp_code(input int unsigned nd, input logic [2:0] m,
                                          input int unsigned idx);
    logic [7:0]  r;
    int unsigned v;
    int unsigned d;
    r = '0;
    v = idx;
    if (is_decimal(m)) begin
      for (int unsigned k = 0; k < nd; k++) begin
        d = v % 10;
        v = v / 10;
        if (m == MODE_AIKEN && d >= 5) d = d + 6;
        else if (m == MODE_XS3) d = d + 3;
        r[4*k +: 4] = d[3:0];
      end
    end else if (m == MODE_GRAY) begin
      r = 8'(idx ^ (idx >> 1));
    end else begin
      r = 8'(idx);
    end
    return r;
  endfunction

  task automatic model_step();
    int unsigned n;
    int unsigned end_idx;
    bit          dn;
    dn = cur_down();
    for (int u = 0; u < 2; u++) begin
      n       = seq_len(u + 1, m_mode[u]);
      end_idx = dn ? 0 : n - 1;
      if (reset) begin
        m_idx[u] = 0; m_mode[u] = (u == 0) ? MODE_BIN : MODE_BCD; m_wr[u] = 1'b0;
      end else if (clr) begin
        m_idx[u] = 0; m_mode[u] = mode; m_wr[u] = 1'b0;
      end else if (en) begin
        if (m_idx[u] == end_idx) begin
          m_wr[u] = wrap;
          if (wrap) m_idx[u] = dn ? n - 1 : 0;
        end else begin
          m_wr[u]  = 1'b0;
          m_idx[u] = dn ? m_idx[u] - 1 : m_idx[u] + 1;
        end
      end else begin
        m_wr[u] = 1'b0;
      end
    end
  endtask

  task automatic check_dut(input int u, input logic [7:0] code_o, input logic last_o,
                           input logic wr_o);
    logic [7:0]  ec;
    logic        el;
    int unsigned n;
    n  = seq_len(u + 1, m_mode[u]);
    ec = exp_code(u + 1, m_mode[u], m_idx[u]);
    el = (m_idx[u] == (cur_down() ? 0 : n - 1));
    vectors++;
    assert (code_o === ec) else begin
      miscompares++;
      $error("FAIL code[u%0d] t=%0t observed=%h expected=%h", u, $time, code_o, ec);
    end
    vectors++;
    assert (last_o === el) else begin
      miscompares++;
      $error("FAIL last[u%0d] t=%0t observed=%b expected=%b", u, $time, last_o, el);
    end
    vectors++;
    assert (wr_o === m_wr[u]) else begin
      miscompares++;
      $error("FAIL wrapped[u%0d] t=%0t observed=%b expected=%b", u, $time, wr_o, m_wr[u]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_dut(0, {4'b0000, b1.code}, b1.last, b1.wrapped);
    check_dut(1, b2.code, b2.last, b2.wrapped);
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; en = 1'b0; wrap = 1'b0; mode = MODE_BIN; dir = 1'b0;
    #1;
    repeat (2) cycle();
    reset = 1'b0;

    // Up-count with saturation.
    en = 1'b1; wrap = 1'b0;
    repeat (20) cycle();

    // Gray with wrap; clr together with en.
    clr = 1'b1; mode = MODE_GRAY; wrap = 1'b1;
    cycle();
    clr = 1'b0;
    repeat (17) cycle();

    // BCD full cycle with wrap.
    clr = 1'b1; mode = MODE_BCD;
    cycle();
    clr = 1'b0;
    repeat (105) cycle();

    // Aiken then excess-3, saturating.
    wrap = 1'b0;
    clr = 1'b1; mode = MODE_AIKEN;
    cycle();
    clr = 1'b0;
    repeat (12) cycle();
    clr = 1'b1; mode = MODE_XS3;
    cycle();
    clr = 1'b0;
    repeat (12) cycle();

    // Mode change without clr, enable gap, clr+en, reset mid-run.
    clr = 1'b1; mode = MODE_BIN; wrap = 1'b1;
    cycle();
    clr = 1'b0;
    repeat (5) cycle();
    mode = MODE_GRAY;
    repeat (3) cycle();
    en = 1'b0;
    repeat (3) cycle();
    en = 1'b1;
    repeat (2) cycle();
    clr = 1'b1; mode = MODE_XS3;
    cycle();
    clr = 1'b0;
    repeat (4) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    repeat (3) cycle();

`ifdef CODE_SEQ_DOWN_EN
    // Down-count from first value wraps to the final value.
    clr = 1'b1; mode = MODE_BCD; wrap = 1'b1; dir = 1'b1; en = 1'b1;
    cycle();
    clr = 1'b0;
    repeat (95) cycle();
    wrap = 1'b0;
    repeat (8) cycle();
    dir = 1'b0;
`endif

    // Randomised run.
    repeat (3000) begin
      reset = ($urandom_range(0, 199) == 0);
      clr   = ($urandom_range(0, 39) == 0);
      en    = ($urandom_range(0, 7) != 0);
      wrap  = ($urandom_range(0, 3) != 0);
      mode  = 3'($urandom_range(0, 7));
`ifdef CODE_SEQ_DOWN_EN
      if ($urandom_range(0, 63) == 0) dir = ~dir;
`endif
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
